// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, sequencer state and PC constants
package riscv_pkg;

    localparam logic [4:0] I_TYPE_L = 5'b00000;
    localparam logic [4:0] I_TYPE_A = 5'b00100;
    localparam logic [4:0] S_TYPE   = 5'b01000;
    localparam logic [4:0] SB_TYPE  = 5'b11000;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - branch/sequential next-PC adder with alignment check
module next_pc_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] immediate,
    input  logic            branch_taken,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    // Both sums wrap modulo 2^XLEN by truncation.
    always_comb begin
        target     = branch_taken ? (pc + immediate) : (pc + XLEN'(INSTR_BYTES));
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - one-instruction-at-a-time fetch/execute sequencer
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            exec_done,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] immediate,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic [XLEN-1:0] retire_count,
    output logic            fault
);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic            retire_q, retire_d;
    logic [XLEN-1:0] retire_count_q, retire_count_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] target;
    logic            misaligned;

    next_pc_unit #(.XLEN(XLEN)) u_next_pc (
        .pc           (pc_q),
        .immediate    (immediate),
        .branch_taken (branch_taken),
        .target       (target),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            imem_req_q     <= 1'b0;
            retire_q       <= 1'b0;
            retire_count_q <= '0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            imem_req_q     <= imem_req_d;
            retire_q       <= retire_d;
            retire_count_q <= retire_count_d;
            fault_q        <= fault_d;
        end
    end

    // Registered outputs are computed from the state being entered, so they
    // line up with state_q on the following cycle.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = 1'b0;
        imem_req_d     = 1'b0;
        retire_d       = 1'b0;
        retire_count_d = retire_count_q;
        fault_d        = fault_q;

        case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_EXEC;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            ST_EXEC: begin
                instr_valid_d = 1'b1;
                if (!stall && exec_done) begin
                    instr_valid_d = 1'b0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d           = target;
                        retire_d       = 1'b1;
                        retire_count_d = retire_count_q + 1'b1;
                        imem_req_d     = 1'b1;
                        state_d        = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign pc           = pc_q;
    assign retire       = retire_q;
    assign retire_count = retire_count_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        stall;
    logic        branch_taken;
    logic [31:0] immediate;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] retire_count;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .stall        (stall),
        .branch_taken (branch_taken),
        .immediate    (immediate),
        .pc           (pc),
        .retire       (retire),
        .retire_count (retire_count),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] rdata);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack = 1'b0;
        check("fetch_instr", instr, rdata);
        check("fetch_valid", {31'b0, instr_valid}, 32'd1);
        check("fetch_req_drop", {31'b0, imem_req}, 32'd0);
    endtask

    task automatic do_exec(input logic bt, input logic [31:0] imm,
                           input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        exec_done    = 1'b1;
        branch_taken = bt;
        immediate    = imm;
        step();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        check("exec_retire", {31'b0, retire}, 32'd1);
        check("exec_addr", imem_addr, exp_pc);
        check("exec_count", retire_count, exp_cnt);
        check("exec_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; immediate = '0;
        step();
        step();
        check("rst_pc", pc, 32'h100);
        check("rst_addr", imem_addr, 32'h100);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_count", retire_count, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);

        // IDLE for one cycle, then FETCH
        rst_n = 1'b1;
        step();
        check("idle_to_fetch_req", {31'b0, imem_req}, 32'd1);
        check("idle_to_fetch_addr", imem_addr, 32'h100);

        // back-to-back: 2 cycles per instruction
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h0000_0013);
            check("b2b_retire_low", {31'b0, retire}, 32'd0);
            do_exec(1'b0, 32'h0, 32'h100 + 32'(4 * (i + 1)), 32'(i + 1));
        end

        // ack delayed 3 cycles, with execute inputs wiggling outside EXEC
        exec_done = 1'b1; branch_taken = 1'b1; immediate = 32'h40;
        for (int k = 0; k < 3; k++) begin
            step();
            check("dly_req", {31'b0, imem_req}, 32'd1);
            check("dly_addr", imem_addr, 32'h10C);
            check("dly_instr_hold", instr, 32'h0000_0013);
            check("dly_valid", {31'b0, instr_valid}, 32'd0);
        end
        exec_done = 1'b0; branch_taken = 1'b0; immediate = '0;
        do_fetch(32'hDEAD_BEE3);

        // branches
        do_exec(1'b1, 32'h0000_00F4, 32'h200, 32'd4);
        do_fetch(32'h0000_0063);
        do_exec(1'b1, 32'hFFFF_FFF0, 32'h1F0, 32'd5);
        do_fetch(32'h0000_0063);
        do_exec(1'b1, 32'h0000_0010, 32'h200, 32'd6);
        do_fetch(32'h0000_0063);
        do_exec(1'b1, 32'h0000_0008, 32'h208, 32'd7);

        // stall beats exec_done
        do_fetch(32'h0000_ABCD);
        stall = 1'b1; exec_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_pc", pc, 32'h208);
            check("stall_instr", instr, 32'h0000_ABCD);
            check("stall_count", retire_count, 32'd7);
            check("stall_retire", {31'b0, retire}, 32'd0);
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0; exec_done = 1'b0;
        do_exec(1'b0, 32'h0, 32'h20C, 32'd8);
        step();
        check("stall_single_retire", {31'b0, retire}, 32'd0);
        check("stall_single_count", retire_count, 32'd8);

        // wrap past top of address space
        do_fetch(32'h0000_0013);
        do_exec(1'b1, 32'hFFFF_FDF0, 32'hFFFF_FFFC, 32'd9);
        do_fetch(32'h0000_0013);
        do_exec(1'b0, 32'h0, 32'h0000_0000, 32'd10);

        // misaligned branch target
        do_fetch(32'h0000_0013);
        do_exec(1'b1, 32'h0000_0010, 32'h10, 32'd11);
        do_fetch(32'h0000_0063);
        exec_done = 1'b1; branch_taken = 1'b1; immediate = 32'h6;
        step();
        check("flt_fault", {31'b0, fault}, 32'd1);
        check("flt_pc", pc, 32'h10);
        check("flt_retire", {31'b0, retire}, 32'd0);
        check("flt_count", retire_count, 32'd11);
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("flt_sticky", {31'b0, fault}, 32'd1);
            check("flt_req", {31'b0, imem_req}, 32'd0);
            check("flt_valid", {31'b0, instr_valid}, 32'd0);
            check("flt_pc_hold", pc, 32'h10);
        end
        exec_done = 1'b0; branch_taken = 1'b0; immediate = '0;

        // reset pulse clears the fault; a stray ack during IDLE is ignored
        rst_n = 1'b0;
        #1;
        check("flt_rst_pc", pc, 32'h100);
        check("flt_rst_fault", {31'b0, fault}, 32'd0);
        check("flt_rst_count", retire_count, 32'd0);
        rst_n = 1'b1;
        step();
        check("stray_ack_instr", instr, 32'd0);
        check("stray_ack_valid", {31'b0, instr_valid}, 32'd0);
        check("stray_ack_req", {31'b0, imem_req}, 32'd1);
        imem_ack = 1'b0;

        // asynchronous reset in the middle of a fetch
        step();
        check("midf_req_before", {31'b0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midf_req", {31'b0, imem_req}, 32'd0);
        check("midf_addr", imem_addr, 32'h100);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the single-cycle datapath one instruction at a time.
- Owns the program counter and fetches each instruction over a req/ack handshake to instruction memory.
- Presents the instruction to decode (immediate_generator, control, ALU) and waits for the datapath to report completion.
- Computes the next PC from the branch decision and the generated immediate; a misaligned target traps into a sticky fault.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- XLEN, 32: width of PC, instruction and immediate.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  memory accepted the request; imem_rdata is valid this cycle.
- imem_rdata  input  XLEN  instruction word returned by memory.
- instr  output  XLEN  captured instruction; feeds immediate_generator and control.
- instr_valid  output  1  instr is live for execution.
- exec_done  input  1  datapath has completed the current instruction.
- stall  input  1  freezes the sequencer in EXEC.
- branch_taken  input  1  SB-type branch condition true; sampled with exec_done.
- immediate  input  XLEN  sign-extended immediate from immediate_generator.
- pc  output  XLEN  current program counter.
- retire  output  1  one-cycle pulse per completed instruction.
- retire_count  output  XLEN  number of retired instructions; wraps.
- fault  output  1  sticky misaligned-target fault.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; imem_addr=RESET_PC.
  - retire=0; retire_count=0; fault=0; state=IDLE.
  - Takes effect immediately, including mid-fetch or mid-exec.
  - An imem_ack arriving after reset deasserts is ignored unless a new request is outstanding.
- States: IDLE, FETCH, EXEC, FAULT.
- IDLE: one cycle after reset release -> FETCH. No outputs asserted.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack: instr<=imem_rdata, then -> EXEC.
  - An ack in the first FETCH cycle is legal and accepted.
  - imem_req deasserts in the cycle after ack.
- EXEC:
  - instr_valid=1; instr is held constant.
  - If stall=1: hold state; exec_done is ignored.
  - If stall=0 and exec_done=1, compute target:
    - branch_taken=1: pc+immediate.
    - branch_taken=0: pc+4.
    - Both are modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
  - If target[1:0]==0: pc<=target; retire=1 for one cycle; retire_count++ (wraps); -> FETCH.
  - If target[1:0]!=0: pc unchanged; fault<=1; no retire; -> FAULT.
- FAULT:
  - Terminal state: imem_req=0, instr_valid=0, fault=1.
  - Only reset exits.
- exec_done, branch_taken and immediate are ignored outside EXEC.
- When stall and exec_done are both high, stall wins; the datapath must re-assert exec_done after stall drops.
- Minimum throughput: 2 cycles per instruction (FETCH with same-cycle ack, then EXEC with immediate exec_done).
- All outputs are registered except imem_addr, which is pc routed directly.

Decomposition:
- Shared package riscv_pkg:
  - opcode[6:2] constants (I_TYPE_L 5'b00000, I_TYPE_A 5'b00100, S_TYPE 5'b01000, SB_TYPE 5'b11000).
  - sequencer state encoding.
  - INSTR_BYTES=4 and RESET_PC default.
- One sub-module, next_pc_unit (combinational):
  - Inputs: pc, immediate, branch_taken.
  - Outputs: target, misaligned.
  - Verified standalone.

Test Plan:
- Reset with RESET_PC=0x100, ack in same cycle as req, exec_done next cycle, branch_taken=0 -> imem_addr 0x100 then 0x104; retire pulses every 2 cycles; retire_count=3 after 6 cycles.
- Memory ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr stable; instr captured only on the ack cycle; instr_valid rises the next cycle.
- pc=0x200, branch_taken=1, immediate=0xFFFFFFF0 -> next imem_addr=0x1F0; immediate=0x8 -> 0x208.
- stall=1 with exec_done=1 for 4 cycles -> pc, instr and retire_count unchanged; exec_done after stall drops -> single retire.
- pc=0x10, branch_taken=1, immediate=0x6 -> fault=1, pc stays 0x10, imem_req stays 0 thereafter; rst_n pulse clears to RESET_PC.
- pc=0xFFFFFFFC, no branch -> pc wraps to 0x0; rst_n asserted mid-FETCH -> imem_req=0 in the same cycle.
